// File: rtl/rf_pkg.sv
// rf_pkg
// Shared definitions for the sequential register-file front end.
// - Default index and data widths.
// - 3-bit FSM state encoding (IDLE=0, WR=1, RD1=2, RD2=3, RESP=4).
// No ports; imported by reg_file_seq and usable by any checker that decodes
// the exposed state.
package rf_pkg;

  localparam int REG_IDX_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF    = 32;

  localparam int STATE_WIDTH = 3;

  typedef logic [STATE_WIDTH-1:0] rf_state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_RD2  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/reg_file_seq.sv
// reg_file_seq
// Serialises operand reads (two sources) and writebacks onto a single
// register-file port. Register x0 is hard-wired to zero: writes to it are
// acknowledged but never reach the port, and reads of it return 0 without a
// port strobe.
//
// Ports
//   sys_clk, sys_rst_n      clock (rising edge) / asynchronous active-low reset
//   rd_req_valid/ready      read request handshake; rd_rs1_idx/rd_rs2_idx
//                           are sampled on the accepting edge
//   rd_resp_valid           one-cycle pulse, rs1_data/rs2_data valid
//   rs1_data, rs2_data      operands, held until the next capture or reset
//   wb_valid/ready          writeback handshake; wb_idx/wb_data sampled on
//                           the accepting edge
//   rf_op, rf_rw            register-file port strobe and direction (1=write)
//   rf_idx, rf_data_w       register-file port index and write data
//   rf_data_r               register-file read data (updated on falling edge)
//   busy                    high in any state other than IDLE
//   state_dbg               current FSM state, for checkers and debug
//
// Handshake rule: a request is accepted on a rising edge where its valid and
// ready are both high. valid may not depend on ready; ready is asserted only
// in IDLE and only for the request the arbiter would grant, so at most one
// request is accepted per edge. Both readies are held low while reset is
// asserted so nothing is accepted on an edge that sees reset low.
module reg_file_seq
  import rf_pkg::*;
#(
  parameter int REG_IDX_WIDTH = REG_IDX_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     rd_req_valid,
  input  logic [REG_IDX_WIDTH-1:0] rd_rs1_idx,
  input  logic [REG_IDX_WIDTH-1:0] rd_rs2_idx,
  output logic                     rd_req_ready,
  output logic                     rd_resp_valid,
  output logic [DATA_WIDTH-1:0]    rs1_data,
  output logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     wb_valid,
  input  logic [REG_IDX_WIDTH-1:0] wb_idx,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     wb_ready,
  output logic                     rf_op,
  output logic                     rf_rw,
  output logic [REG_IDX_WIDTH-1:0] rf_idx,
  output logic [DATA_WIDTH-1:0]    rf_data_w,
  input  logic [DATA_WIDTH-1:0]    rf_data_r,
  output logic                     busy,
  output logic [STATE_WIDTH-1:0]   state_dbg
);

  rf_state_t                state;
  logic                     last_wr;
  logic [REG_IDX_WIDTH-1:0] wb_idx_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;
  logic [REG_IDX_WIDTH-1:0] rs1_idx_q;
  logic [REG_IDX_WIDTH-1:0] rs2_idx_q;

  logic idle;
  logic wb_fire;
  logic rd_fire;

  assign idle = (state == ST_IDLE);

  // Two-way priority toggle: with both requests pending, the write wins
  // unless the previous grant was a write. A lone requester always wins.
  assign wb_ready     = sys_rst_n && idle && !(rd_req_valid && last_wr);
  assign rd_req_ready = sys_rst_n && idle && !(wb_valid && !last_wr);

  assign wb_fire = wb_valid && wb_ready;
  assign rd_fire = rd_req_valid && rd_req_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      last_wr       <= 1'b0;
      wb_idx_q      <= '0;
      wb_data_q     <= '0;
      rs1_idx_q     <= '0;
      rs2_idx_q     <= '0;
      rs1_data      <= '0;
      rs2_data      <= '0;
      rd_resp_valid <= 1'b0;
    end else begin
      // Registered so the pulse coincides exactly with the RESP cycle.
      rd_resp_valid <= (state == ST_RD2);
      case (state)
        ST_IDLE: begin
          if (wb_fire) begin
            last_wr <= 1'b1;
            // x0 writes are acknowledged here and never occupy the port.
            if (wb_idx != '0) begin
              wb_idx_q  <= wb_idx;
              wb_data_q <= wb_data;
              state     <= ST_WR;
            end
          end else if (rd_fire) begin
            last_wr   <= 1'b0;
            rs1_idx_q <= rd_rs1_idx;
            rs2_idx_q <= rd_rs2_idx;
            state     <= ST_RD1;
          end
        end
        ST_WR: begin
          state <= ST_IDLE;
        end
        ST_RD1: begin
          rs1_data <= (rs1_idx_q == '0) ? '0 : rf_data_r;
          state    <= ST_RD2;
        end
        ST_RD2: begin
          rs2_data <= (rs2_idx_q == '0) ? '0 : rf_data_r;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port signals come only from state and latched registers, so nothing on
  // the request inputs can reach the register-file port combinationally.
  always_comb begin
    rf_op     = 1'b0;
    rf_rw     = 1'b0;
    rf_idx    = '0;
    rf_data_w = '0;
    case (state)
      ST_WR: begin
        rf_op     = 1'b1;
        rf_rw     = 1'b1;
        rf_idx    = wb_idx_q;
        rf_data_w = wb_data_q;
      end
      ST_RD1: begin
        rf_op  = (rs1_idx_q != '0);
        rf_idx = rs1_idx_q;
      end
      ST_RD2: begin
        rf_op  = (rs2_idx_q != '0);
        rf_idx = rs2_idx_q;
      end
      default: begin
        rf_op = 1'b0;
      end
    endcase
  end

  assign busy      = !idle;
  assign state_dbg = state;

endmodule

// File: tb/tb_reg_file_seq.sv
// tb_reg_file_seq
// Directed bench for reg_file_seq. A behavioural register file sits on the
// rf_* port. Drivers push expected read responses and expected grant order
// into queues; a monitor on the falling edge pops and compares whenever the
// DUT accepts a request or presents a response.
module tb_reg_file_seq;

  localparam int IW = 5;
  localparam int DW = 32;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          rd_req_valid;
  logic [IW-1:0] rd_rs1_idx;
  logic [IW-1:0] rd_rs2_idx;
  logic          rd_req_ready;
  logic          rd_resp_valid;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          rf_op;
  logic          rf_rw;
  logic [IW-1:0] rf_idx;
  logic [DW-1:0] rf_data_w;
  logic [DW-1:0] rf_data_r;
  logic          busy;
  logic [2:0]    state_dbg;

  reg_file_seq #(.REG_IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rd_req_valid (rd_req_valid),
    .rd_rs1_idx   (rd_rs1_idx),
    .rd_rs2_idx   (rd_rs2_idx),
    .rd_req_ready (rd_req_ready),
    .rd_resp_valid(rd_resp_valid),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .rf_op        (rf_op),
    .rf_rw        (rf_rw),
    .rf_idx       (rf_idx),
    .rf_data_w    (rf_data_w),
    .rf_data_r    (rf_data_r),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // ---------------- behavioural register file ----------------
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  initial rf_data_r = '0;
  always @(negedge sys_clk) begin
    if (rf_op && rf_rw) rf_mem[rf_idx] = rf_data_w;
    rf_data_r = (rf_op && !rf_rw) ? rf_mem[rf_idx] : '0;
  end

  // ---------------- scoreboard ----------------
  logic [2*DW-1:0] exp_q[$];
  logic [0:0]      grant_exp_q[$];   // 1 = write grant, 0 = read grant
  int              rd_acc_q[$];      // edge index of each read acceptance
  int total = 0;
  int bad   = 0;
  int rd_strobes = 0;
  int wr_strobes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (wb_valid && wb_ready) begin
        if (grant_exp_q.size() == 0) check("unexpected_wr_grant", 64'(1), 64'(0));
        else check("grant_order_wr", 64'(1), 64'(grant_exp_q.pop_front()));
      end
      if (rd_req_valid && rd_req_ready) begin
        if (grant_exp_q.size() == 0) check("unexpected_rd_grant", 64'(1), 64'(0));
        else check("grant_order_rd", 64'(0), 64'(grant_exp_q.pop_front()));
        rd_acc_q.push_back(cyc + 1);
      end
      if (rf_op) begin
        if (rf_rw) wr_strobes++;
        else begin
          rd_strobes++;
          check("rd_strobe_wdata_zero", 64'(rf_data_w), 64'(0));
        end
        check("strobe_idx_nonzero", 64'(rf_idx != '0), 64'(1));
      end
      if (rd_resp_valid) begin
        check("resp_port_idle", 64'(rf_op), 64'(0));
        if (exp_q.size() == 0) check("unexpected_resp", 64'(1), 64'(0));
        else check("resp_data", {rs1_data, rs2_data}, exp_q.pop_front());
        // Accepted on edge A; RD1, RD2, RESP follow one cycle each, so the
        // response is presented in the third cycle, just after edge A+2.
        if (rd_acc_q.size() == 0) check("resp_without_accept", 64'(1), 64'(0));
        else check("resp_latency", 64'(cyc), 64'(rd_acc_q.pop_front() + 2));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr_handshake(input logic [IW-1:0] idx, input logic [DW-1:0] data,
                              input bit push_grant);
    bit ok = 0;
    int n = 0;
    wb_idx   = idx;
    wb_data  = data;
    wb_valid = 1'b1;
    if (push_grant) grant_exp_q.push_back(1'b1);
    while (!ok && n < 50) begin
      @(negedge sys_clk);
      n++;
      if (wb_ready) begin
        @(posedge sys_clk);
        #1;
        ok = 1;
      end
    end
    check("wr_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic rd_handshake(input logic [IW-1:0] rs1, input logic [IW-1:0] rs2,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                              input bit push_exp, input bit push_grant, output int acc);
    bit ok = 0;
    int n = 0;
    rd_rs1_idx   = rs1;
    rd_rs2_idx   = rs2;
    rd_req_valid = 1'b1;
    acc = -1;
    if (push_exp) exp_q.push_back({e1, e2});
    if (push_grant) grant_exp_q.push_back(1'b0);
    while (!ok && n < 50) begin
      @(negedge sys_clk);
      n++;
      if (rd_req_ready) begin
        @(posedge sys_clk);
        #1;
        ok = 1;
        acc = cyc;
      end
    end
    check("rd_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] data);
    wr_handshake(idx, data, 1'b1);
    wb_valid = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] rs1, input logic [IW-1:0] rs2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    int acc;
    rd_handshake(rs1, rs2, e1, e2, 1'b1, 1'b1, acc);
    rd_req_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int acc_a, acc_b, snap;
  logic [DW-1:0] wr_vals [4] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};

  initial begin
    sys_rst_n    = 1'b0;
    rd_req_valid = 1'b0;
    rd_rs1_idx   = '0;
    rd_rs2_idx   = '0;
    wb_valid     = 1'b1;          // pending during reset: must not be taken
    wb_idx       = 5'd9;
    wb_data      = 32'hBAD0_BAD0;

    // Reset state, with a request pending through several reset edges.
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_wb_ready", 64'(wb_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rf_op", 64'(rf_op), 64'(0));
    check("rst_resp_valid", 64'(rd_resp_valid), 64'(0));
    check("rst_rs_data", {rs1_data, rs2_data}, 64'(0));
    wb_valid = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check("post_rst_state", 64'(state_dbg), 64'(0));
    check("post_rst_no_write", 64'(wr_strobes), 64'(0));

    // Write x5, then read x5/x0: one port read strobe only.
    do_write(5'd5, 32'hDEAD_BEEF);
    check("wr_state_is_wr", 64'(state_dbg), 64'(1));
    check("wr_port_idx", 64'(rf_idx), 64'(5));
    check("wr_port_data", 64'(rf_data_w), 64'(32'hDEAD_BEEF));
    wait_cycles(1);
    check("wr_occupancy_2", 64'(busy), 64'(0));
    snap = rd_strobes;
    do_read(5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
    wait_cycles(4);
    check("x5_x0_rd_strobes", 64'(rd_strobes - snap), 64'(1));

    // Write x0 is acknowledged without a port write; reading x0 gives 0.
    snap = wr_strobes;
    do_write(5'd0, 32'h1234_5678);
    check("x0_wr_stays_idle", 64'(busy), 64'(0));
    wait_cycles(1);
    check("x0_wr_no_strobe", 64'(wr_strobes - snap), 64'(0));
    snap = rd_strobes;
    do_read(5'd0, 5'd0, 32'h0, 32'h0);
    wait_cycles(4);
    check("x0_rd_no_strobe", 64'(rd_strobes - snap), 64'(0));

    // Same-cycle write x7 / read x7 with last_wr clear: write goes first.
    grant_exp_q.push_back(1'b1);
    grant_exp_q.push_back(1'b0);
    fork
      begin
        wr_handshake(5'd7, 32'h0000_0055, 1'b0);
        wb_valid = 1'b0;
      end
      begin
        rd_handshake(5'd7, 5'd0, 32'h0000_0055, 32'h0, 1'b1, 1'b0, acc_a);
        rd_req_valid = 1'b0;
      end
    join
    wait_cycles(4);

    // Both requesters saturated for 4 requests each: W,R,W,R,...
    // Read k reads x(10+k), already written, and x(11+k), not yet written.
    for (int i = 0; i < 4; i++) begin
      grant_exp_q.push_back(1'b1);
      grant_exp_q.push_back(1'b0);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) wr_handshake(IW'(10 + i), wr_vals[i], 1'b0);
        wb_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int a;
          rd_handshake(IW'(10 + j), IW'(11 + j), wr_vals[j], 32'h0, 1'b1, 1'b0, a);
        end
        rd_req_valid = 1'b0;
      end
    join
    wait_cycles(4);

    // Back-to-back reads with swapped operands.
    do_write(5'd3, 32'h0000_0033);
    do_write(5'd4, 32'h0000_0044);
    wait_cycles(1);
    rd_handshake(5'd3, 5'd4, 32'h33, 32'h44, 1'b1, 1'b1, acc_a);
    rd_handshake(5'd4, 5'd3, 32'h44, 32'h33, 1'b1, 1'b1, acc_b);
    rd_req_valid = 1'b0;
    check("b2b_read_spacing", 64'(acc_b - acc_a), 64'(4));
    wait_cycles(4);

    // Reset asserted during RD2 drops the read.
    rd_handshake(5'd3, 5'd4, 32'h0, 32'h0, 1'b0, 1'b1, acc_a);
    rd_req_valid = 1'b0;
    wait_cycles(1);
    check("rd2_state", 64'(state_dbg), 64'(3));
    check("rd2_port_idx", 64'(rf_idx), 64'(4));
    check("rd2_port_op", 64'(rf_op), 64'(1));
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_rf_op", 64'(rf_op), 64'(0));
    check("async_rst_rf_idx", 64'(rf_idx), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_rs_data", {rs1_data, rs2_data}, 64'(0));
    rd_acc_q.delete();
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_cycles(6);   // any stray response here hits an empty queue
    do_read(5'd4, 5'd3, 32'h44, 32'h33);
    wait_cycles(4);

    // Drain.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge sys_clk);
    check("drain_resp_q", 64'(exp_q.size()), 64'(0));
    check("drain_grant_q", 64'(grant_exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
